// File: rtl/signed_divider.sv
// Iterative 16/8 signed divider: restoring shift-subtract, one quotient bit per cycle.
// Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor and raises div_zero.
module signed_divider (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        div_zero
);

  localparam int unsigned DW = 16;
  localparam int unsigned VW = 8;
  localparam int unsigned RW = VW + 1;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {IDLE, LOAD, DIVIDE, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] qsh_q, qsh_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [RW-1:0] dvs_mag_q, dvs_mag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overflow_q, overflow_d;
`ifdef DIV_ZERO_DETECT_EN
  logic          dz_q, dz_d;
  logic          div_zero_q, div_zero_d;
`endif

  logic [RW:0]   trial;
  logic [RW:0]   diff;
  logic          fits;
  logic          dvd_neg;
  logic          dvs_neg;

  // One restoring step: bring down the next dividend bit and try to subtract.
  always_comb begin
    trial   = {rem_q, qsh_q[DW-1]};
    diff    = trial - {1'b0, dvs_mag_q};
    fits    = (trial >= {1'b0, dvs_mag_q});
    dvd_neg = dvd_q[DW-1];
    dvs_neg = dvs_q[VW-1];
  end

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    qsh_d       = qsh_q;
    rem_d       = rem_q;
    dvs_mag_d   = dvs_mag_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
`ifdef DIV_ZERO_DETECT_EN
    dz_d        = dz_q;
    div_zero_d  = div_zero_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end

      LOAD: begin
        qsh_d     = dvd_neg ? DW'(-dvd_q) : dvd_q;
        dvs_mag_d = dvs_neg ? RW'(-{dvs_q[VW-1], dvs_q}) : {dvs_q[VW-1], dvs_q};
        rem_d     = '0;
        cnt_d     = '0;
        state_d   = DIVIDE;
`ifdef DIV_ZERO_DETECT_EN
        dz_d = (dvs_q == '0);
        // A zero divisor skips the iterations and only passes through FIX.
        if (dvs_q == '0) begin
          state_d = FIX;
        end
`endif
      end

      DIVIDE: begin
        rem_d   = fits ? RW'(diff) : RW'(trial);
        qsh_d   = {qsh_q[DW-2:0], fits};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        quotient_d  = (dvd_neg ^ dvs_neg) ? DW'(-qsh_q) : qsh_q;
        remainder_d = dvd_neg ? VW'(-rem_q) : VW'(rem_q);
        overflow_d  = (dvd_q == 16'h8000) && (dvs_q == 8'hFF);
`ifdef DIV_ZERO_DETECT_EN
        div_zero_d = dz_q;
        if (dz_q) begin
          quotient_d  = 16'hFFFF;
          remainder_d = dvd_q[VW-1:0];
          overflow_d  = 1'b0;
        end
`endif
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      qsh_q       <= '0;
      rem_q       <= '0;
      dvs_mag_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dz_q        <= 1'b0;
      div_zero_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      qsh_q       <= qsh_d;
      rem_q       <= rem_d;
      dvs_mag_q   <= dvs_mag_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
`ifdef DIV_ZERO_DETECT_EN
      dz_q        <= dz_d;
      div_zero_q  <= div_zero_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero  = div_zero_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: expected results queued at issue, popped at done.
module tb_signed_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        div_zero;

  int total = 0;
  int bad = 0;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
    bit          chk_val;
    int          lat;
  } exp_t;

  exp_t sb[$];

  signed_divider dut (
    .CLK100MHZ (clk),
    .reset     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sd, qi, ri;
    sa = int'($signed(a));
    sd = int'($signed(b));
    e.ovf = 1'b0;
    e.dz = 1'b0;
    e.chk_val = 1'b1;
    e.lat = 18;
    e.q = '0;
    e.r = '0;
    if (sd == 0) begin
      if (DZ_EN) begin
        e.q = 16'hFFFF;
        e.r = a[7:0];
        e.dz = 1'b1;
        e.lat = 2;
      end else begin
        e.chk_val = 1'b0;
      end
    end else if (sa == -32768 && sd == -1) begin
      e.q = 16'h8000;
      e.ovf = 1'b1;
    end else begin
      qi = sa / sd;
      ri = sa % sd;
      e.q = 16'(qi);
      e.r = 8'(ri);
    end
    return e;
  endfunction

  // Drive one request; returns just after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] b, input bit hold);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Edges from the accepting edge to done; -1 on timeout. Leaves the FSM back in IDLE.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({quotient, remainder, busy, done, overflow, div_zero} !== 28'd0) begin
      bad++;
      $display("FAIL reset_outputs: got q=%h r=%h b=%b d=%b o=%b z=%b want all 0",
               quotient, remainder, busy, done, overflow, div_zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] ta[10];
    logic [7:0]  tb[10];
    int lat;
    exp_t e;
    ta = '{16'd56, -16'sd100, 16'd100, 16'd21, 16'd127, 16'h8000, 16'd32767, 16'hFFFF, -16'sd7, 16'd1234};
    tb = '{8'd7,   8'd7,      -8'sd7,  -8'sd4, 8'h80,   8'd1,     8'hFF,     8'd1,     8'd100,  8'h80};
    for (int i = 0; i < 16; i++) begin
      if (i < 10) issue(ta[i], tb[i], 1'b0);
      else issue(16'($urandom), 8'($urandom_range(1, 255)), 1'b0);
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL basic_busy[%0d]: got %b want 1", i, busy);
      end
      wait_done(lat);
      e = sb.pop_front();
      total++;
      if (lat !== e.lat) begin
        bad++;
        $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, e.lat);
      end
      total++;
      if (quotient !== e.q || remainder !== e.r) begin
        bad++;
        $display("FAIL basic_result[%0d]: got q=%h r=%h want q=%h r=%h", i, quotient, remainder, e.q, e.r);
      end
      total++;
      if (overflow !== e.ovf || div_zero !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL basic_flags[%0d]: got o=%b z=%b d=%b b=%b want o=%b z=0 d=0 b=0",
                 i, overflow, div_zero, done, busy, e.ovf);
      end
    end
  endtask

  task automatic test_overflow();
    int lat;
    exp_t e;
    issue(16'h8000, 8'hFF, 1'b0);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (quotient !== 16'h8000 || remainder !== 8'h00 || overflow !== 1'b1 || lat !== e.lat) begin
      bad++;
      $display("FAIL ovf_case: got q=%h r=%h o=%b lat=%0d want q=8000 r=00 o=1 lat=%0d",
               quotient, remainder, overflow, lat, e.lat);
    end
    issue(16'd8, 8'd8, 1'b0);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (quotient !== e.q || remainder !== e.r || overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: got q=%h r=%h o=%b want q=%h r=%h o=0", quotient, remainder, overflow, e.q, e.r);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    exp_t e;
    issue(16'd300, 8'd0, 1'b0);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat !== e.lat || div_zero !== e.dz || overflow !== 1'b0) begin
      bad++;
      $display("FAIL dz_timing: got lat=%0d z=%b o=%b want lat=%0d z=%b o=0", lat, div_zero, overflow, e.lat, e.dz);
    end
    if (e.chk_val) begin
      total++;
      if (quotient !== e.q || remainder !== e.r) begin
        bad++;
        $display("FAIL dz_result: got q=%h r=%h want q=%h r=%h", quotient, remainder, e.q, e.r);
      end
    end
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    exp_t e;
    seen = 0;
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 2 || i == 4) start = 1'b1;
      else start = 1'b0;
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({quotient, remainder, busy, done, overflow, div_zero} !== 28'd0) begin
      bad++;
      $display("FAIL abort_outputs: got q=%h r=%h b=%b d=%b o=%b z=%b want all 0",
               quotient, remainder, busy, done, overflow, div_zero);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    total++;
    if (seen != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done: got pulses=%0d busy=%b want pulses=0 busy=0", seen, busy);
    end
    issue(16'd21, -8'sd4, 1'b0);
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (quotient !== 16'hFFFB || remainder !== 8'h01 || lat !== 18) begin
      bad++;
      $display("FAIL abort_recover: got q=%h r=%h lat=%0d want q=fffb r=01 lat=18", quotient, remainder, lat);
    end
    total++;
    if (quotient !== e.q || remainder !== e.r) begin
      bad++;
      $display("FAIL abort_model: got q=%h r=%h want q=%h r=%h", quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    exp_t e;
    issue(-16'sd100, 8'd7, 1'b1);
    dividend = 16'd777;
    divisor  = -8'sd9;
    sb.push_back(model(16'd777, -8'sd9));
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    e = sb.pop_front();
    total++;
    if (lat !== 18 || quotient !== e.q || remainder !== e.r) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d q=%h r=%h want lat=18 q=%h r=%h", lat, quotient, remainder, e.q, e.r);
    end
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle_gap: got busy=%b want 0", busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: got busy=%b want 1", busy);
    end
    wait_done(lat);
    e = sb.pop_front();
    total++;
    if (lat !== 18 || quotient !== e.q || remainder !== e.r) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d q=%h r=%h want lat=18 q=%h r=%h", lat, quotient, remainder, e.q, e.r);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_div_zero();
    test_abort();
    test_back_to_back();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
